// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared state, access-size and error encodings for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE   = 2'd0;
  localparam state_t c_ST_ACCESS = 2'd1;
  localparam state_t c_ST_RESP   = 2'd2;

  localparam logic [2:0] c_SZ_B  = 3'b000;
  localparam logic [2:0] c_SZ_H  = 3'b001;
  localparam logic [2:0] c_SZ_W  = 3'b010;
  localparam logic [2:0] c_SZ_BU = 3'b100;
  localparam logic [2:0] c_SZ_HU = 3'b101;

  localparam logic [1:0] c_ERR_OK       = 2'b00;
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_SIZE     = 2'b10;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

  function automatic logic size_legal(input logic [2:0] sz);
    return sz inside {c_SZ_B, c_SZ_H, c_SZ_W, c_SZ_BU, c_SZ_HU};
  endfunction

  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] lo);
    case (sz)
      c_SZ_H, c_SZ_HU: return lo[0];
      c_SZ_W:          return lo != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte enables, store lane replication and load lane extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] w_lane;

  // Addressed byte moved down to bit 0 so every size extracts from the bottom.
  assign w_lane = rdata_word >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = rdata_word;
    case (size)
      c_SZ_B:  load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      c_SZ_BU: load_data = {24'b0, w_lane[7:0]};
      c_SZ_H:  load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      c_SZ_HU: load_data = {16'b0, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit with stall, error and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic [2:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam int               c_CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic            r_we;
  logic [2:0]      r_size;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [1:0]      r_err;
  logic [c_CW-1:0] r_cnt;

  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep;
  logic [31:0]     w_load_data;
  logic            w_accept;

  lsu_align u_align (
    .size       (r_size),
    .addr_lo    (r_addr[1:0]),
    .wdata      (r_wdata),
    .rdata_word (dmem_rdata),
    .be         (w_be),
    .wdata_rep  (w_wdata_rep),
    .load_data  (w_load_data)
  );

  assign w_accept   = (r_state == c_ST_IDLE) && req_valid;
  assign dmem_req   = (r_state == c_ST_ACCESS);
  // Reset term keeps stall low while reset is held even if req_valid is high.
  assign stall      = (w_accept && reset) || dmem_req;
  assign resp_valid = (r_state == c_ST_RESP);
  assign dmem_we    = dmem_req & r_we;
  assign dmem_be    = dmem_req ? w_be : 4'b0000;
  assign dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem_wdata = w_wdata_rep;
  assign rdata      = r_rdata;
  assign err        = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= c_ERR_OK;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (req_valid) begin
            r_we    <= mem_write;
            r_size  <= mem_size;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_rdata <= 32'h0;
            r_err   <= c_ERR_OK;
            r_cnt   <= '0;
            if (!size_legal(mem_size)) begin
              r_err   <= c_ERR_SIZE;
              r_state <= c_ST_RESP;
            end else if (misaligned(mem_size, addr[1:0])) begin
              r_err   <= c_ERR_MISALIGN;
              r_state <= c_ST_RESP;
            end else begin
              r_state <= c_ST_ACCESS;
            end
          end
        end
        c_ST_ACCESS: begin
          if (dmem_ready) begin
            r_rdata <= r_we ? 32'h0 : w_load_data;
            r_err   <= c_ERR_OK;
            r_state <= c_ST_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rdata <= 32'h0;
            r_err   <= c_ERR_TIMEOUT;
            r_state <= c_ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_RESP: begin
          r_cnt   <= '0;
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
